// File: rtl/fight_logic_if.sv
// Player action buttons and display outputs of the fighting-game core,
// bundled so the game logic and its environment share one connection.
interface fight_logic_if;
    // Player-1 action buttons
    logic       punch1;
    logic       kick1;
    logic       wait1;
    logic       jump1;
    logic       left1;
    logic       right1;
    // Player-2 action buttons
    logic       punch2;
    logic       kick2;
    logic       wait2;
    logic       jump2;
    logic       left2;
    logic       right2;
    // Display outputs
    logic [1:0] hp1;
    logic       pos11;
    logic       pos12;
    logic       pos13;
    logic [1:0] hp2;
    logic       pos21;
    logic       pos22;
    logic       pos23;

    // Environment side: drives buttons, observes game state
    modport master (
        output punch1, kick1, wait1, jump1, left1, right1,
        output punch2, kick2, wait2, jump2, left2, right2,
        input  hp1, pos11, pos12, pos13,
        input  hp2, pos21, pos22, pos23
    );

    // Game-logic side: samples buttons, drives game state
    modport slave (
        input  punch1, kick1, wait1, jump1, left1, right1,
        input  punch2, kick2, wait2, jump2, left2, right2,
        output hp1, pos11, pos12, pos13,
        output hp2, pos21, pos22, pos23
    );
endinterface

// File: rtl/fight_logic.sv
// Core state machine of a two-player, one-dimensional fighting game.
// Positions are kept one-hot per player (1 = own edge, 3 = centre); each
// enabled cycle both players' actions are resolved simultaneously, attacks
// using the positions held at the start of the cycle.
module fight_logic #(
    parameter logic [1:0] HP_INIT     = 2'd3,
    parameter int         PUNCH_REACH = 1,
    parameter int         KICK_REACH  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    fight_logic_if.slave  bus
);

    localparam logic [2:0] PUNCH_REACH_L = 3'(PUNCH_REACH);
    localparam logic [2:0] KICK_REACH_L  = 3'(KICK_REACH);
    localparam logic [2:0] POS_EDGE      = 3'b001;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_IDLE  = 3'd0,
        ACT_JUMP  = 3'd1,
        ACT_PUNCH = 3'd2,
        ACT_KICK  = 3'd3,
        ACT_FWD   = 3'd4,
        ACT_BACK  = 3'd5
    } act_t;

    // Priority decode: jump > punch > kick > forward > backward > wait/none
    function automatic act_t decode_action(
        input logic jump_b,
        input logic punch_b,
        input logic kick_b,
        input logic fwd_b,
        input logic back_b,
        input logic wait_b
    );
        act_t a;
        if (jump_b) begin
            a = ACT_JUMP;
        end else if (punch_b) begin
            a = ACT_PUNCH;
        end else if (kick_b) begin
            a = ACT_KICK;
        end else if (fwd_b) begin
            a = ACT_FWD;
        end else if (back_b) begin
            a = ACT_BACK;
        end else if (wait_b) begin
            a = ACT_IDLE;
        end else begin
            a = ACT_IDLE;
        end
        return a;
    endfunction

    // One-hot position to index 1..3; an illegal code reads as the edge
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd1;
            3'b010:  idx = 2'd2;
            3'b100:  idx = 2'd3;
            default: idx = 2'd1;
        endcase
        return idx;
    endfunction

    // Move one step towards the centre, saturating there
    function automatic logic [2:0] step_fwd(input logic [2:0] oh);
        logic [2:0] r;
        case (oh)
            3'b001:  r = 3'b010;
            3'b010:  r = 3'b100;
            3'b100:  r = 3'b100;
            default: r = POS_EDGE;
        endcase
        return r;
    endfunction

    // Move one step towards the own edge, saturating there
    function automatic logic [2:0] step_back(input logic [2:0] oh);
        logic [2:0] r;
        case (oh)
            3'b001:  r = 3'b001;
            3'b010:  r = 3'b001;
            3'b100:  r = 3'b010;
            default: r = POS_EDGE;
        endcase
        return r;
    endfunction

    // Health after one hit, saturating at zero
    function automatic logic [1:0] hp_hit(input logic [1:0] hp);
        return (hp == 2'd0) ? 2'd0 : (hp - 2'd1);
    endfunction

    state_t     state_q, state_d;
    logic [1:0] hp1_q, hp1_d;
    logic [1:0] hp2_q, hp2_d;
    logic [2:0] pos1_q, pos1_d;
    logic [2:0] pos2_q, pos2_d;

    act_t       act1_s;
    act_t       act2_s;
    logic [2:0] dist_s;
    logic       hit_on2_s;
    logic       hit_on1_s;
    logic       clash_s;

    // Decode actions and resolve hits from start-of-cycle positions
    always_comb begin
        act1_s = decode_action(bus.jump1, bus.punch1, bus.kick1,
                               bus.right1, bus.left1, bus.wait1);
        act2_s = decode_action(bus.jump2, bus.punch2, bus.kick2,
                               bus.left2, bus.right2, bus.wait2);
        dist_s = 3'd7 - {1'b0, onehot_to_idx(pos1_q)} - {1'b0, onehot_to_idx(pos2_q)};
        hit_on2_s = (act2_s != ACT_JUMP) &&
                    (((act1_s == ACT_PUNCH) && (dist_s <= PUNCH_REACH_L)) ||
                     ((act1_s == ACT_KICK)  && (dist_s <= KICK_REACH_L)));
        hit_on1_s = (act1_s != ACT_JUMP) &&
                    (((act2_s == ACT_PUNCH) && (dist_s <= PUNCH_REACH_L)) ||
                     ((act2_s == ACT_KICK)  && (dist_s <= KICK_REACH_L)));
        // Adjacent players both stepping in block each other
        clash_s = (dist_s == 3'd1) && (act1_s == ACT_FWD) && (act2_s == ACT_FWD);
    end

    // Next-state logic: play update when enabled, otherwise hold
    always_comb begin
        state_d = state_q;
        hp1_d   = hp1_q;
        hp2_d   = hp2_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        case (state_q)
            ST_PLAY: begin
                if (en) begin
                    if (hit_on1_s) begin
                        hp1_d = hp_hit(hp1_q);
                    end else begin
                        hp1_d = hp1_q;
                    end
                    if (hit_on2_s) begin
                        hp2_d = hp_hit(hp2_q);
                    end else begin
                        hp2_d = hp2_q;
                    end
                    if (clash_s) begin
                        pos1_d = pos1_q;
                        pos2_d = pos2_q;
                    end else begin
                        case (act1_s)
                            ACT_FWD:  pos1_d = step_fwd(pos1_q);
                            ACT_BACK: pos1_d = step_back(pos1_q);
                            default:  pos1_d = pos1_q;
                        endcase
                        case (act2_s)
                            ACT_FWD:  pos2_d = step_fwd(pos2_q);
                            ACT_BACK: pos2_d = step_back(pos2_q);
                            default:  pos2_d = pos2_q;
                        endcase
                    end
                    if ((hp1_d == 2'd0) || (hp2_d == 2'd0)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_OVER;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_PLAY;
            hp1_q   <= HP_INIT;
            hp2_q   <= HP_INIT;
            pos1_q  <= POS_EDGE;
            pos2_q  <= POS_EDGE;
        end else begin
            state_q <= state_d;
            hp1_q   <= hp1_d;
            hp2_q   <= hp2_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
        end
    end

    assign bus.hp1   = hp1_q;
    assign bus.pos11 = pos1_q[0];
    assign bus.pos12 = pos1_q[1];
    assign bus.pos13 = pos1_q[2];
    assign bus.hp2   = hp2_q;
    assign bus.pos21 = pos2_q[0];
    assign bus.pos22 = pos2_q[1];
    assign bus.pos23 = pos2_q[2];

endmodule

// File: tb/tb_fight_logic.sv
// Directed testbench for fight_logic: a linear sequence of button patterns
// with hand-computed health and position expectations after each clock.
module tb_fight_logic;

    logic clk;
    logic reset;
    logic en;
    int   n_tests;
    int   n_fail;

    fight_logic_if bus ();

    fight_logic dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    // Action encodings {jump, punch, kick, wait, left, right}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] J    = 6'b100000;
    localparam logic [5:0] P    = 6'b010000;
    localparam logic [5:0] K    = 6'b001000;
    localparam logic [5:0] W    = 6'b000100;
    localparam logic [5:0] L    = 6'b000010;
    localparam logic [5:0] R    = 6'b000001;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] onehot(input int p);
        logic [2:0] r;
        case (p)
            1:       r = 3'b001;
            2:       r = 3'b010;
            3:       r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [5:0] a1, input logic [5:0] a2);
        bus.jump1  = a1[5];
        bus.punch1 = a1[4];
        bus.kick1  = a1[3];
        bus.wait1  = a1[2];
        bus.left1  = a1[1];
        bus.right1 = a1[0];
        bus.jump2  = a2[5];
        bus.punch2 = a2[4];
        bus.kick2  = a2[3];
        bus.wait2  = a2[2];
        bus.left2  = a2[1];
        bus.right2 = a2[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] e_hp1, input int e_p1,
                              input logic [1:0] e_hp2, input int e_p2);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {bus.hp1, bus.pos13, bus.pos12, bus.pos11,
               bus.hp2, bus.pos23, bus.pos22, bus.pos21};
        exp = {e_hp1, onehot(e_p1), e_hp2, onehot(e_p2)};
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed hp1/pos1/hp2/pos2=%b expected %b", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        en      = 1'b0;
        drive(NONE, NONE);

        tick();
        expect_out("reset", 2'd3, 1, 2'd3, 1);

        reset = 1'b1;
        en    = 1'b1;
        drive(R, L);
        tick();
        expect_out("approach1", 2'd3, 2, 2'd3, 2);
        tick();
        expect_out("approach2", 2'd3, 3, 2'd3, 3);
        tick();
        expect_out("approach_blocked", 2'd3, 3, 2'd3, 3);

        drive(P, P);
        tick();
        expect_out("trade_punch", 2'd2, 3, 2'd2, 3);
        drive(K, L);
        tick();
        expect_out("kick_vs_fwd", 2'd2, 3, 2'd1, 3);
        drive(R, P);
        tick();
        expect_out("punch_vs_fwd", 2'd1, 3, 2'd1, 3);
        drive(J, P);
        tick();
        expect_out("jump1_dodge", 2'd1, 3, 2'd1, 3);
        drive(K | P, J | P);
        tick();
        expect_out("jump2_prio_dodge", 2'd1, 3, 2'd1, 3);

        drive(P, K);
        tick();
        expect_out("double_ko", 2'd0, 3, 2'd0, 3);
        drive(L, P | R);
        tick();
        expect_out("over_frozen1", 2'd0, 3, 2'd0, 3);
        drive(L | W, R);
        tick();
        expect_out("over_frozen2", 2'd0, 3, 2'd0, 3);

        reset = 1'b0;
        drive(P, K);
        tick();
        expect_out("reset_from_over", 2'd3, 1, 2'd3, 1);

        reset = 1'b1;
        drive(R, L);
        tick();
        expect_out("replay_move1", 2'd3, 2, 2'd3, 2);
        tick();
        expect_out("replay_move2", 2'd3, 3, 2'd3, 3);

        en = 1'b0;
        drive(P | L, NONE);
        tick();
        expect_out("en_low_hold", 2'd3, 3, 2'd3, 3);
        en = 1'b1;
        drive(P, NONE);
        tick();
        expect_out("en_high_punch", 2'd3, 3, 2'd2, 3);

        drive(L, W);
        tick();
        expect_out("retreat_d2", 2'd3, 2, 2'd2, 3);
        drive(NONE, K);
        tick();
        expect_out("kick_d2_hits", 2'd2, 2, 2'd2, 3);
        drive(P, NONE);
        tick();
        expect_out("punch_d2_miss", 2'd2, 2, 2'd2, 3);
        drive(L, NONE);
        tick();
        expect_out("retreat_d3", 2'd2, 1, 2'd2, 3);
        drive(NONE, K);
        tick();
        expect_out("kick_d3_miss", 2'd2, 1, 2'd2, 3);
        drive(L, NONE);
        tick();
        expect_out("back_saturate", 2'd2, 1, 2'd2, 3);
        drive(J | R, R);
        tick();
        expect_out("jump_no_move_p2_back", 2'd2, 1, 2'd2, 2);

        drive(NONE, P);
        drive(P, K);
        reset = 1'b0;
        tick();
        expect_out("reset_mid_game", 2'd3, 1, 2'd3, 1);

        reset = 1'b1;
        drive(NONE, NONE);
        tick();
        expect_out("idle_after_reset", 2'd3, 1, 2'd3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
